// File: rtl/y_sram_writer_if.sv
// Y-result stream and Y SRAM write port of the Y-update writer.
// The datapath drives in_yData/in_yValid; the writer drives op_yReady and the SRAM write bus.
interface y_sram_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
);
    // Handshake: a word transfers at a rising edge where in_yValid && op_yReady.
    // op_yReady never depends on in_yValid; in_yData must be stable while in_yValid is high.
    logic [ACC_WIDTH-1:0]  in_yData;
    logic                  in_yValid;
    logic                  op_yReady;
    logic [ADDR_WIDTH-1:0] op_ySramAddr;
    logic [DATA_WIDTH-1:0] op_ySramWriteData;
    logic                  op_ySramWriteEnable;

    modport slave (
        input  in_yData,
        input  in_yValid,
        output op_yReady,
        output op_ySramAddr,
        output op_ySramWriteData,
        output op_ySramWriteEnable
    );

    modport master (
        output in_yData,
        output in_yValid,
        input  op_yReady,
        input  op_ySramAddr,
        input  op_ySramWriteData,
        input  op_ySramWriteEnable
    );
endinterface

// File: rtl/y_sram_writer.sv
// Y SRAM write engine: buffers NUM_Y results in a small FIFO and writes them to consecutive addresses.
// Define YWRITE_SATURATE_EN to saturate incoming results instead of truncating them.
module y_sram_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_Y      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_rst,
    input  logic             in_writeYvalEnable,
    y_sram_writer_if.slave   y_bus,
    output logic             op_updateYwriteDoneFlag,
    output logic             op_writeBusy,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   NUM_CNT  = (ADDR_WIDTH+1)'(NUM_Y);
    localparam logic [PW:0]           FULL_CNT = (PW+1)'(FIFO_DEPTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           fill;
    logic [ADDR_WIDTH:0]   accept_count;
    logic [ADDR_WIDTH:0]   write_count;
    logic [DATA_WIDTH-1:0] in_word;
    logic                  push;
    logic                  pop;
    logic                  last_pop;

`ifdef YWRITE_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        in_word = y_bus.in_yData[DATA_WIDTH-1:0];
        if ($signed(y_bus.in_yData) > SAT_MAX) begin
            in_word = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if ($signed(y_bus.in_yData) < SAT_MIN) begin
            in_word = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end
`else
    // Plain truncation: the upper accumulator bits are dropped and values wrap.
    logic [ACC_WIDTH-1:0] unused_acc_bits;
    assign unused_acc_bits = y_bus.in_yData;
    assign in_word = y_bus.in_yData[DATA_WIDTH-1:0];
`endif

    assign y_bus.op_yReady = (state == ST_WRITE) && (fill != FULL_CNT) && (accept_count < NUM_CNT);
    assign push     = y_bus.in_yValid && y_bus.op_yReady;
    assign pop      = (state == ST_WRITE) && (fill != '0) && (write_count < NUM_CNT);
    assign last_pop = pop && (write_count == NUM_CNT - 1'b1);
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                     <= ST_IDLE;
            rd_ptr                    <= '0;
            wr_ptr                    <= '0;
            fill                      <= '0;
            accept_count              <= '0;
            write_count               <= '0;
            y_bus.op_ySramAddr        <= BASE;
            y_bus.op_ySramWriteData   <= '0;
            y_bus.op_ySramWriteEnable <= 1'b0;
            op_updateYwriteDoneFlag   <= 1'b0;
            op_writeBusy              <= 1'b0;
        end else if (soft_rst) begin
            state                     <= ST_IDLE;
            rd_ptr                    <= '0;
            wr_ptr                    <= '0;
            fill                      <= '0;
            accept_count              <= '0;
            write_count               <= '0;
            y_bus.op_ySramAddr        <= BASE;
            y_bus.op_ySramWriteData   <= '0;
            y_bus.op_ySramWriteEnable <= 1'b0;
            op_updateYwriteDoneFlag   <= 1'b0;
            op_writeBusy              <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    y_bus.op_ySramWriteEnable <= 1'b0;
                    op_updateYwriteDoneFlag   <= 1'b0;
                    if (in_writeYvalEnable) begin
                        state              <= ST_WRITE;
                        op_writeBusy       <= 1'b1;
                        rd_ptr             <= '0;
                        wr_ptr             <= '0;
                        fill               <= '0;
                        accept_count       <= '0;
                        write_count        <= '0;
                        y_bus.op_ySramAddr <= BASE;
                    end
                end
                ST_WRITE: begin
                    if (push) begin
                        wr_ptr       <= wr_ptr + 1'b1;
                        accept_count <= accept_count + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr                    <= rd_ptr + 1'b1;
                        write_count               <= write_count + 1'b1;
                        y_bus.op_ySramAddr        <= BASE + write_count[ADDR_WIDTH-1:0];
                        y_bus.op_ySramWriteData   <= mem[rd_ptr];
                        y_bus.op_ySramWriteEnable <= 1'b1;
                    end else begin
                        y_bus.op_ySramWriteEnable <= 1'b0;
                    end
                    case ({push, pop})
                        2'b10:   fill <= fill + 1'b1;
                        2'b01:   fill <= fill - 1'b1;
                        default: fill <= fill;
                    endcase
                    if (last_pop) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The final strobe is on the bus this cycle; the pulse follows it.
                    y_bus.op_ySramWriteEnable <= 1'b0;
                    op_updateYwriteDoneFlag   <= 1'b1;
                    op_writeBusy              <= 1'b0;
                    state                     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
